addsub_frame_accumulator: RTL and testbench

- Streaming stage placed directly downstream of the two-operand signed add/sub datapath.
- Per beat, computes the term (+/-a)+(+/-b) using invert-plus-carry-constant negation (carry constant 0, 1 or 2), registers it, and accumulates terms over a frame delimited by in_last.
- Presents the frame sum, beat count and overflow flag on a valid/ready output port.
- Used to reduce bursts of signed partial products/differences before the normalisation stage.

---
 rtl/addsub_frame_accumulator.sv | 86 ++++++++
 tb/tb_addsub_frame_accumulator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_frame_accumulator.sv
// addsub_frame_accumulator: registers a (+/-a)+(+/-b) term per beat, accumulates a frame up to in_last, holds the result on a valid/ready port.
// Define ADDSUB_FRAME_ACC_SAT_EN to clamp the accumulator on signed overflow instead of wrapping.
module addsub_frame_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 48,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_neg_a,
    input  logic                 in_neg_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t state, state_nx;
    logic s1_full, s1_last, in_fire, drain, out_fire, ovf, ovf_add;
    logic [WIDTH-1:0] s1_term, term;
    logic [ACC_WIDTH-1:0] acc, acc_base, ext, sum, acc_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_base, cnt_nx;

    // Negation is invert plus a carry constant of 0, 1 or 2 for the two operands together
    assign term     = (in_a ^ {WIDTH{in_neg_a}}) + (in_b ^ {WIDTH{in_neg_b}}) + WIDTH'({in_neg_a & in_neg_b, in_neg_a ^ in_neg_b});
    assign in_ready = ~s1_full | (state != HOLD);
    assign in_fire  = in_valid & in_ready;
    assign drain    = s1_full & (state != HOLD);
    assign out_fire = (state == HOLD) & out_ready;
    assign ext      = ACC_WIDTH'($signed(s1_term));
    // A drain in IDLE starts a new frame, so it adds onto zero
    assign acc_base = (state == IDLE) ? '0 : acc;
    assign cnt_base = (state == IDLE) ? '0 : cnt;
    assign sum      = acc_base + ext;
    assign ovf_add  = (acc_base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) & (sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
    assign cnt_nx   = &cnt_base ? cnt_base : cnt_base + 1'b1;
`ifdef ADDSUB_FRAME_ACC_SAT_EN
    assign acc_nx   = ovf_add ? (acc_base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}}) : sum;
`else
    assign acc_nx   = sum;
`endif

    always_comb begin
        state_nx = state;
        state_nx = drain ? (s1_last ? HOLD : ACCUM) : out_fire ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s1_full <= 1'b0;
            s1_last <= 1'b0;
            s1_term <= '0;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nx;
            s1_full <= in_fire | (s1_full & ~drain);
            if (in_fire) begin
                s1_term <= term;
                s1_last <= in_last;
            end
            if (drain) begin
                acc <= acc_nx;
                cnt <= cnt_nx;
                ovf <= ((state != IDLE) & ovf) | ovf_add;
            end else if (out_fire) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end

    assign out_valid = (state == HOLD);
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_ovf   = ovf;
endmodule

// File: tb/tb_addsub_frame_accumulator.sv
// tb_addsub_frame_accumulator: scoreboard bench with an arithmetic reference model, WIDTH=8 ACC_WIDTH=12 CNT_WIDTH=4.
module tb_addsub_frame_accumulator;
    typedef struct packed {
        logic [11:0] sum;
        logic [3:0]  cnt;
        logic        ovf;
    } res_t;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_ready, in_neg_a = 0, in_neg_b = 0, in_last = 0;
    logic [7:0] in_a = 0, in_b = 0;
    logic out_valid, out_ready = 0, out_ovf;
    logic [11:0] out_sum;
    logic [3:0] out_count;
    int total = 0, bad = 0, rdy_mode = 1;
    res_t exp_q[$];

    addsub_frame_accumulator #(.WIDTH(8), .ACC_WIDTH(12), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_neg_a(in_neg_a), .in_neg_b(in_neg_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 0) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 1);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_result got sum=%h cnt=%0d ovf=%0b required none", out_sum, out_count, out_ovf);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if ({out_sum, out_count, out_ovf} !== e) begin
                    bad++;
                    $display("FAIL frame_result got sum=%h cnt=%0d ovf=%0b required sum=%h cnt=%0d ovf=%0b",
                             out_sum, out_count, out_ovf, e.sum, e.cnt, e.ovf);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic na, input logic nb, input logic last);
        int w = 0;
        @(negedge clk);
        in_valid = 1; in_a = a; in_b = b; in_neg_a = na; in_neg_b = nb; in_last = last;
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_timeout got 0 required 1");
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain_wait();
        int w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    function automatic int term_model(input logic [7:0] a, input logic [7:0] b, input logic na, input logic nb);
        int sa = $signed(a), sb = $signed(b), t;
        t = (na ? -sa : sa) + (nb ? -sb : sb);
        t = t & 255;
        return (t > 127) ? t - 256 : t;
    endfunction

    initial begin
        logic [7:0] ra[20], rb[20];
        logic rna[20], rnb[20];
        // reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1;
        check("idle_out_sum", out_sum, 0);
        check("idle_out_count", out_count, 0);
        check("idle_out_ovf", out_ovf, 0);
        repeat (2) @(negedge clk);

        // single beat latency: 5 + (-3)
        exp_q.push_back('{12'd2, 4'd1, 1'b0});
        send(8'd5, 8'd3, 0, 1, 1);
        @(negedge clk) check("lat_n", out_valid, 0);
        @(negedge clk) check("lat_n1", out_valid, 1);
        @(negedge clk) check("lat_after", out_valid, 0);

        // carry constants 0, 1, 2
        exp_q.push_back('{12'd23, 4'd3, 1'b0});
        send(8'd10, 8'd20, 0, 0, 0);
        send(8'd7, 8'd2, 1, 0, 0);
        send(8'd1, 8'd1, 1, 1, 1);
        drain_wait();

        // term wraps at WIDTH
        exp_q.push_back('{12'hFC8, 4'd1, 1'b0});
        send(8'd100, 8'd100, 0, 0, 1);
        drain_wait();

        // accumulator overflow and count saturation
`ifdef ADDSUB_FRAME_ACC_SAT_EN
        exp_q.push_back('{12'h7FF, 4'd15, 1'b1});
`else
        exp_q.push_back('{12'h86F, 4'd15, 1'b1});
`endif
        for (int i = 0; i < 17; i++) send(8'd127, 8'd0, 0, 0, i == 16);
        drain_wait();

        // backpressure: one beat parks in stage 1 while the result is held
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        exp_q.push_back('{12'd2, 4'd1, 1'b0});
        send(8'd1, 8'd1, 0, 0, 1);
        begin
            int w = 0;
            while (!out_valid && w < 20) begin @(negedge clk); w++; end
        end
        check("bp_hold_valid", out_valid, 1);
        exp_q.push_back('{12'd7, 4'd1, 1'b0});
        send(8'd3, 8'd4, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid_held", out_valid, 1);
        end
        rdy_mode = 1;
        drain_wait();

        // reset mid-frame
        send(8'd5, 8'd5, 0, 0, 0);
        send(8'd6, 8'd6, 0, 0, 0);
        @(negedge clk) rst_n = 0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_ovf", out_ovf, 0);
        check("mid_rst_in_ready", in_ready, 1);
        rst_n = 1;
        exp_q.push_back('{12'd0, 4'd1, 1'b0});
        send(8'd2, 8'd2, 0, 1, 1);
        drain_wait();

        // random frames against the arithmetic model
        rdy_mode = 0;
        for (int f = 0; f < 40; f++) begin
            int n, acc, s;
            logic ov;
            n = $urandom_range(1, 20);
            acc = 0; ov = 0;
            for (int i = 0; i < n; i++) begin
                ra[i] = 8'($urandom); rb[i] = 8'($urandom);
                rna[i] = 1'($urandom); rnb[i] = 1'($urandom);
                s = acc + term_model(ra[i], rb[i], rna[i], rnb[i]);
                if (s > 2047 || s < -2048) begin
                    ov = 1;
`ifdef ADDSUB_FRAME_ACC_SAT_EN
                    s = (s > 2047) ? 2047 : -2048;
`else
                    s = (s > 2047) ? s - 4096 : s + 4096;
`endif
                end
                acc = s;
            end
            exp_q.push_back('{12'(acc), 4'((n > 15) ? 15 : n), ov});
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                send(ra[i], rb[i], rna[i], rnb[i], i == n - 1);
            end
        end
        rdy_mode = 1;
        drain_wait();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
